if_fetch_ctrl: RTL
==================

// Module: if_fetch_ctrl
// PURPOSE
//  Fetch sequencer for the IF stage: owns the PC, issues instruction-memory reads,
//  buffers returned words and hands {pc,instr} to ID over a valid/ready handshake.
//  Handles redirects (branch/jump/trap), halt, and discards stale in-flight reads.
//  Sits between instruction memory and the IF/ID boundary; replaces the free-running PC.
// PARAMETERS
//  RESET_PC    32'h0000_0000  PC of the first fetch after reset
//  FIFO_DEPTH  2              fetch buffer entries; minimum 2
// PORTS
//  clk             in   1   clock; all state updates on posedge
//  reset           in   1   asynchronous, active-high reset
//  imem_req        out  1   read request this cycle; memory always accepts
//  imem_addr       out  32  read address, word aligned; valid when imem_req=1
//  imem_rdata      in   32  read data, valid exactly 1 cycle after imem_req
//  id_valid        out  1   buffer head valid
//  id_ready        in   1   ID accepts the head this cycle
//  id_pc           out  32  PC of the head entry
//  id_instr        out  32  instruction word of the head entry
//  redirect_valid  in   1   redirect the PC to redirect_pc, flush everything
//  redirect_pc     in   32  redirect target; bits [1:0] forced to 0
//  halt            in   1   level: suspend new fetches while high
// BEHAVIOUR
//  Reset: pc=RESET_PC, state=BOOT, fifo empty, inflight=0, epoch=0.
//   imem_req=0, id_valid=0, id_pc=0, id_instr=0 while reset is asserted.
//  FSM states:
//   BOOT: no request. Next state is HALTED if halt=1, otherwise FETCH.
//   FETCH: go to HALTED when halt=1.
//   HALTED: no requests; go to FETCH when halt=0.
//  Issue rule, FETCH only: imem_req = !redirect_valid && (count+inflight-pop) < FIFO_DEPTH.
//   pop = id_valid & id_ready; imem_addr = pc.
//   On issue: pc <= pc+4, mod 2^32 (32'hFFFF_FFFC wraps to 0).
//   Tag the read with the current epoch; inflight <= 1. The credit rule sustains 1 instr/cycle.
//  Response: one cycle after issue, push {issued_pc, imem_rdata} into the FIFO only if
//   tag==epoch; otherwise drop it. Because of the credit rule the FIFO can never overflow.
//  Output: id_valid = fifo not empty; id_pc/id_instr = head entry, registered storage.
//   Head and valid stay stable until popped.
//  Redirect (any state, priority over everything):
//   pc <= {redirect_pc[31:2],2'b00}; flush FIFO; epoch toggles; imem_req=0 that cycle.
//   State unchanged, except BOOT moves on normally.
//   Timing: redirect in C0 -> req at target in C1 -> rdata in C2 -> id_valid in C3.
//  Simultaneous events:
//   pop + redirect: handshake completes, FIFO is then flushed.
//   halt + redirect: pc is updated, then HALTED.
//   Response arriving in the redirect cycle: dropped (old epoch).
//  Halt: in-flight response is still captured; FIFO keeps draining to ID.
//  Reset mid-operation: all state cleared asynchronously; any pending response is ignored.
//  Widths: count is $clog2(FIFO_DEPTH+1) bits; inflight is 1 bit.
// CONFIGURATION
//  IF_PERF_CNT_EN defined: adds ports
//   perf_fetch_cnt  out 32  +1 per ID handshake
//   perf_bubble_cnt out 32  +1 per cycle with state==FETCH && !id_valid
//   Both reset to 0, wrap at 2^32, and are not cleared by redirect.
//  IF_PERF_CNT_EN undefined: these ports and counters are absent; behaviour otherwise identical.
// STRUCTURE
//  Shared package if_pkg: FSM state encoding (BOOT/FETCH/HALTED), RESET_PC default,
//   ALIGN_MASK 32'hFFFF_FFFC, INSTR_NOP 32'h0000_0013 (bench fill value).
//  Sub-module if_fetch_fifo: synchronous FIFO of {pc,instr}, FIFO_DEPTH entries.
//   Provides push/pop/flush, count, head outputs; flush has priority over push.
//  Top level: FSM, PC register, epoch/inflight tracking, credit issue logic, perf counters.
// TESTING
//  T1 reset release, id_ready=1, halt=0, 1-cycle memory model (word = addr):
//   req at 0,4,8,... every cycle from cycle 2; id_pc/id_instr = 0,4,8 back to back.
//  T2 id_ready=0 for 5 cycles:
//   exactly FIFO_DEPTH words buffered, imem_req=0, id_pc holds 0.
//   After release, no word lost or duplicated.
//  T3 redirect_valid=1, redirect_pc=32'h0000_1003, with an outstanding read to 0x10:
//   0x10 never appears on ID; next req at 0x1000; id_pc=0x1000 three cycles later.
//  T4 halt=1 for 4 cycles mid-stream:
//   no req while halted; buffered words still drain.
//   After deassert, fetch resumes at the next sequential PC.
//  T5 redirect to 32'hFFFF_FFF8, id_ready=1:
//   id_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
//  T6 assert reset for 1 cycle during a T2 stall:
//   outputs 0 immediately; restart at RESET_PC with an empty FIFO.
//   With IF_PERF_CNT_EN, counters read 0.

Source files
------------

// File: rtl/if_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | if_pkg : shared constants and types for the IF fetch sequencer      |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package if_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] ALIGN_MASK       = 32'hFFFF_FFFC;
  localparam logic [31:0] INSTR_NOP        = 32'h0000_0013;

  localparam logic [1:0] ST_BOOT   = 2'd0;
  localparam logic [1:0] ST_FETCH  = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return addr & ALIGN_MASK;
  endfunction

endpackage
`default_nettype wire

// File: rtl/if_fetch_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | if_fetch_fifo : circular buffer of {pc,instr}; flush beats push     |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module if_fetch_fifo
  import if_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  fetch_entry_t               push_data,
  input  logic                       pop,
  input  logic                       flush,
  output fetch_entry_t               head,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  fetch_entry_t  mem_q [DEPTH];
  fetch_entry_t  mem_d [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    do_pop   = pop && (count_q != '0);
    do_push  = push && ((count_q != CW'(DEPTH)) || do_pop);
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (do_pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/if_fetch_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | if_fetch_ctrl : IF-stage PC owner, imem read issue, ID handshake    |
// | Optional perf counters: define IF_PERF_CNT_EN                       |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module if_fetch_ctrl
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_pc,
  output logic [31:0] id_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_bubble_cnt
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH+1);

  logic [1:0]    state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic          epoch_q, epoch_d;
  logic          inflight_q, inflight_d;
  logic          tag_q, tag_d;
  logic [31:0]   issued_pc_q, issued_pc_d;

  logic [CW-1:0] fifo_count;
  logic [CW:0]   credit_use;
  logic          pop, push;
  fetch_entry_t  resp_entry, head;

  assign id_valid = (fifo_count != '0);
  assign pop      = id_valid && id_ready;
  assign id_pc    = head.pc;
  assign id_instr = head.instr;

  // Slots already promised (buffered + in flight) after this cycle's pop.
  assign credit_use = {1'b0, fifo_count} + (CW+1)'(inflight_q) - (CW+1)'(pop);
  assign imem_req   = (state_q == ST_FETCH) && !redirect_valid &&
                      (credit_use < (CW+1)'(FIFO_DEPTH));
  assign imem_addr  = pc_q;

  assign push       = inflight_q && (tag_q == epoch_q);
  assign resp_entry = '{pc: issued_pc_q, instr: imem_rdata};

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_BOOT:   state_d = halt ? ST_HALTED : ST_FETCH;
      ST_FETCH:  if (halt)  state_d = ST_HALTED;
      ST_HALTED: if (!halt) state_d = ST_FETCH;
      default:   state_d = ST_BOOT;
    endcase

    pc_d        = pc_q;
    epoch_d     = epoch_q ^ redirect_valid;
    inflight_d  = imem_req;
    tag_d       = tag_q;
    issued_pc_d = issued_pc_q;
    if (redirect_valid) begin
      pc_d = align_pc(redirect_pc);
    end else if (imem_req) begin
      pc_d        = pc_q + 32'd4;
      tag_d       = epoch_q;
      issued_pc_d = pc_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_BOOT;
      pc_q        <= RESET_PC;
      epoch_q     <= 1'b0;
      inflight_q  <= 1'b0;
      tag_q       <= 1'b0;
      issued_pc_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      epoch_q     <= epoch_d;
      inflight_q  <= inflight_d;
      tag_q       <= tag_d;
      issued_pc_q <= issued_pc_d;
    end
  end

  if_fetch_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (resp_entry),
    .pop       (pop),
    .flush     (redirect_valid),
    .head      (head),
    .count     (fifo_count)
  );

`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] bubble_cnt_q, bubble_cnt_d;

  always_comb begin
    fetch_cnt_d  = fetch_cnt_q + 32'(pop);
    bubble_cnt_d = bubble_cnt_q + 32'((state_q == ST_FETCH) && !id_valid);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      fetch_cnt_q  <= fetch_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign perf_fetch_cnt  = fetch_cnt_q;
  assign perf_bubble_cnt = bubble_cnt_q;
`endif

endmodule
`default_nettype wire
